// File: rtl/vdg_fetch_sequencer.sv
// Display timing and VRAM fetch sequencer: dot/line counters, MC6847-style
// display addressing, one-byte-per-period VRAM fetch and sync/blank aligned to Load.
module vdg_fetch_sequencer #(
  parameter logic [8:0] H_ACTIVE     = 9'd256,
  parameter logic [8:0] H_TOTAL      = 9'd456,
  parameter logic [8:0] H_SYNC_START = 9'd296,
  parameter logic [8:0] H_SYNC_LEN   = 9'd34,
  parameter logic [8:0] V_ACTIVE     = 9'd192,
  parameter logic [8:0] V_TOTAL      = 9'd262,
  parameter logic [8:0] V_SYNC_START = 9'd226,
  parameter logic [8:0] V_SYNC_LEN   = 9'd2,
  parameter int         RD_LAT       = 2
) (
  input  logic        Clk,
  input  logic        nReset,
  input  logic [3:0]  Mode,
  input  logic [12:0] StartAddr,
  input  logic [7:0]  VramData,
  output logic [12:0] Addr,
  output logic        VramRd,
  output logic [7:0]  Data,
  output logic        Load,
  output logic        Divider,
  output logic [3:0]  Row,
  output logic        HSync_n,
  output logic        FSync_n,
  output logic        Blank
);

  localparam int DLY = RD_LAT + 1;

  logic [8:0]        r_hcount, r_vcount;
  logic              r_bpl16;
  logic [3:0]        r_rows;
  logic [12:0]       r_line_base, r_addr;
  logic [3:0]        r_row;
  logic [RD_LAT-1:0] r_rd_pipe;
  logic [7:0]        r_data;
  logic              r_load;
  logic [DLY-1:0]    r_blank_pipe, r_hs_pipe, r_fs_pipe;

  logic        w_h_wrap, w_v_wrap, w_line_active, w_frame_start;
  logic        w_m_bpl16, w_bpl16, w_slot, w_fetch;
  logic        w_row_end, w_row_last, w_capture;
  logic [3:0]  w_m_rows;
  logic [4:0]  w_k;
  logic [12:0] w_base;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_m_bpl16 = 1'b0;
    w_m_rows  = 4'd12;
    if (Mode[3]) begin
      case (Mode[2:0])
        3'b000, 3'b001: begin w_m_bpl16 = 1'b1; w_m_rows = 4'd3; end
        3'b010:         begin w_m_bpl16 = 1'b0; w_m_rows = 4'd3; end
        3'b011:         begin w_m_bpl16 = 1'b1; w_m_rows = 4'd2; end
        3'b100:         begin w_m_bpl16 = 1'b0; w_m_rows = 4'd2; end
        3'b101:         begin w_m_bpl16 = 1'b1; w_m_rows = 4'd1; end
        default:        begin w_m_bpl16 = 1'b0; w_m_rows = 4'd1; end
      endcase
    end
  end

  assign w_h_wrap      = (r_hcount == H_TOTAL - 9'd1);
  assign w_v_wrap      = (r_vcount == V_TOTAL - 9'd1);
  assign w_line_active = (r_vcount < V_ACTIVE);
  assign w_frame_start = (r_hcount == 9'd0) && (r_vcount == 9'd0);

  // The hcount==0 fetch must already see this line's mode and, at frame
  // start, the freshly sampled base, since both are latched on that same edge.
  assign w_bpl16 = (r_hcount == 9'd0) ? w_m_bpl16 : r_bpl16;
  assign w_base  = w_frame_start ? StartAddr : r_line_base;
  assign w_slot  = w_bpl16 ? (r_hcount[3:0] == 4'd0) : (r_hcount[2:0] == 3'd0);
  assign w_fetch = w_line_active && (r_hcount < H_ACTIVE) && w_slot;
  assign w_k     = w_bpl16 ? {1'b0, r_hcount[7:4]} : r_hcount[7:3];

  assign w_row_end  = (r_hcount == H_ACTIVE - 9'd1) && w_line_active;
  assign w_row_last = ({1'b0, r_row} + 5'd1) >= {1'b0, r_rows};
  assign w_capture  = r_rd_pipe[RD_LAT-1];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_hcount <= '0;
      r_vcount <= '0;
    end else if (w_h_wrap) begin
      r_hcount <= '0;
      r_vcount <= w_v_wrap ? 9'd0 : r_vcount + 9'd1;
    end else begin
      r_hcount <= r_hcount + 9'd1;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_bpl16     <= 1'b0;
      r_rows      <= 4'd12;
      r_line_base <= '0;
      r_row       <= '0;
      r_addr      <= '0;
    end else begin
      if (r_hcount == 9'd0) begin
        r_bpl16 <= w_m_bpl16;
        r_rows  <= w_m_rows;
      end
      if (w_fetch)
        r_addr <= w_base + {8'd0, w_k};
      if (w_frame_start)
        r_line_base <= StartAddr;
      else if (w_row_end && w_row_last)
        r_line_base <= r_line_base + (r_bpl16 ? 13'd16 : 13'd32);
      // Row>=R after a mid-row mode change also closes the row.
      if (w_h_wrap && w_v_wrap)
        r_row <= '0;
      else if (w_row_end)
        r_row <= w_row_last ? 4'd0 : r_row + 4'd1;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_rd_pipe    <= '0;
      r_data       <= '0;
      r_load       <= 1'b0;
      r_blank_pipe <= '1;
      r_hs_pipe    <= '1;
      r_fs_pipe    <= '1;
    end else begin
      r_rd_pipe[0]    <= w_fetch;
      r_blank_pipe[0] <= !(w_line_active && (r_hcount < H_ACTIVE));
      r_hs_pipe[0]    <= !((r_hcount >= H_SYNC_START) &&
                           (r_hcount < H_SYNC_START + H_SYNC_LEN));
      r_fs_pipe[0]    <= !((r_vcount >= V_SYNC_START) &&
                           (r_vcount < V_SYNC_START + V_SYNC_LEN));
      for (int i = 1; i < RD_LAT; i++)
        r_rd_pipe[i] <= r_rd_pipe[i-1];
      for (int i = 1; i < DLY; i++) begin
        r_blank_pipe[i] <= r_blank_pipe[i-1];
        r_hs_pipe[i]    <= r_hs_pipe[i-1];
        r_fs_pipe[i]    <= r_fs_pipe[i-1];
      end
      r_load <= w_capture;
      if (w_capture)
        r_data <= VramData;
    end
  end

  assign Addr    = r_addr;
  assign VramRd  = r_rd_pipe[0];
  assign Data    = r_data;
  assign Load    = r_load;
  assign Divider = r_bpl16;
  assign Row     = r_row;
  assign HSync_n = r_hs_pipe[DLY-1];
  assign FSync_n = r_fs_pipe[DLY-1];
  assign Blank   = r_blank_pipe[DLY-1];

endmodule

// File: tb/tb_vdg_fetch_sequencer.sv
// Self-checking bench: directed mode scenarios plus randomized mode/base churn,
// compared every cycle against a line/slot arithmetic model and a latency-exact VRAM.
module tb_vdg_fetch_sequencer;

  localparam int RD_LAT = 2;
  localparam int LAT    = RD_LAT + 1;
  localparam int LINE   = 456;

  logic        Clk = 1'b0;
  logic        nReset = 1'b0;
  logic [3:0]  Mode = 4'b1111;
  logic [12:0] StartAddr = 13'h0400;
  logic [7:0]  VramData = 8'h00;
  logic [12:0] Addr;
  logic        VramRd, Load, Divider, HSync_n, FSync_n, Blank;
  logic [7:0]  Data;
  logic [3:0]  Row;

  always #5 Clk = ~Clk;

  vdg_fetch_sequencer #(.RD_LAT(RD_LAT)) dut (
    .Clk(Clk), .nReset(nReset), .Mode(Mode), .StartAddr(StartAddr),
    .VramData(VramData), .Addr(Addr), .VramRd(VramRd), .Data(Data),
    .Load(Load), .Divider(Divider), .Row(Row), .HSync_n(HSync_n),
    .FSync_n(FSync_n), .Blank(Blank)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem [8192];

  // Model state: line/dot position of the current cycle plus latched mode.
  int mh, mv, m_bpl, m_rows, m_base, m_row, cc;
  bit m_div, e_rd;
  logic [12:0] e_addr;
  logic [7:0]  e_data;
  bit          ld_q [16];
  logic [12:0] ld_addr [16];
  bit          bl_q [16], hs_q [16], fs_q [16];
  bit          vr_v [16];
  logic [12:0] vr_a [16];

  bit         sw_en;
  int         sw_h;
  logic [3:0] sw_mode;

  int bpl_t  [8] = '{16, 16, 32, 16, 32, 16, 32, 32};
  int rows_t [8] = '{3, 3, 3, 2, 2, 1, 1, 1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, line %0d dot %0d)",
               tag, got, exp, cc, mv, mh);
    end
  endtask

  task automatic model_reset();
    mh = 0; mv = 0; m_bpl = 32; m_rows = 12; m_base = 0; m_row = 0; cc = 0;
    m_div = 0; e_rd = 0; e_addr = '0; e_data = '0;
    for (int i = 0; i < 16; i++) begin
      ld_q[i] = 0; bl_q[i] = 1; hs_q[i] = 1; fs_q[i] = 1; vr_v[i] = 0;
    end
  endtask

  task automatic check_outputs();
    int i;
    i = cc % 16;
    check("VramRd", VramRd, e_rd);
    check("Addr", Addr, e_addr);
    if (ld_q[i]) e_data = mem[ld_addr[i]];
    check("Load", Load, ld_q[i]);
    ld_q[i] = 0;
    check("Data", Data, e_data);
    check("Blank", Blank, bl_q[i]);
    check("HSync_n", HSync_n, hs_q[i]);
    check("FSync_n", FSync_n, fs_q[i]);
    check("Divider", Divider, m_div);
    check("Row", Row, m_row);
  endtask

  // Memory answers the DUT's own strobe, with data valid only in the capture cycle.
  task automatic vram_drive();
    if (VramRd) begin
      vr_v[(cc + RD_LAT - 1) % 16] = 1;
      vr_a[(cc + RD_LAT - 1) % 16] = Addr;
    end
    if (vr_v[cc % 16]) begin
      VramData = mem[vr_a[cc % 16]];
      vr_v[cc % 16] = 0;
    end else begin
      VramData = 8'($urandom());
    end
  endtask

  task automatic model_step();
    int p, d;
    if (mh == 0) begin
      m_bpl  = Mode[3] ? bpl_t[Mode[2:0]] : 32;
      m_rows = Mode[3] ? rows_t[Mode[2:0]] : 12;
      m_div  = (m_bpl == 16);
      if (mv == 0) m_base = int'(StartAddr);
    end
    p = 256 / m_bpl;
    d = (cc + LAT) % 16;
    e_rd = (mv < 192) && (mh < 256) && (mh % p == 0);
    if (e_rd) begin
      e_addr = 13'((m_base + mh / p) % 8192);
      ld_q[d] = 1;
      ld_addr[d] = e_addr;
    end
    bl_q[d] = !(mh < 256 && mv < 192);
    hs_q[d] = !(mh >= 296 && mh < 330);
    fs_q[d] = !(mv >= 226 && mv < 228);
    if (mh == 255 && mv < 192) begin
      if (m_row + 1 >= m_rows) begin
        m_row = 0;
        m_base = (m_base + m_bpl) % 8192;
      end else begin
        m_row++;
      end
    end
    mh++;
    if (mh == LINE) begin
      mh = 0;
      mv++;
      if (mv == 262) begin mv = 0; m_row = 0; end
    end
    cc++;
  endtask

  task automatic run_cycles(input int n, input bit rnd);
    for (int c = 0; c < n; c++) begin
      check_outputs();
      if (sw_en && mv == 0 && mh == sw_h) Mode = sw_mode;
      if (rnd) begin
        if ($urandom_range(0, 199) == 0) Mode = 4'($urandom());
        if ($urandom_range(0, 99) == 0) StartAddr = 13'($urandom());
      end
      vram_drive();
      model_step();
      @(negedge Clk);
    end
  endtask

  task automatic do_reset(input logic [3:0] mode, input logic [12:0] sa);
    #2 nReset = 1'b0;
    #1;
    check("rst_Addr", Addr, 13'h0);
    check("rst_VramRd", VramRd, 1'b0);
    check("rst_Data", Data, 8'h0);
    check("rst_Load", Load, 1'b0);
    check("rst_Divider", Divider, 1'b0);
    check("rst_Row", Row, 4'h0);
    check("rst_HSync_n", HSync_n, 1'b1);
    check("rst_FSync_n", FSync_n, 1'b1);
    check("rst_Blank", Blank, 1'b1);
    Mode = mode;
    StartAddr = sa;
    sw_en = 0;
    @(negedge Clk);
    nReset = 1'b1;
    model_reset();
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom());
    sw_en = 0;
    model_reset();
    repeat (2) @(negedge Clk);
    nReset = 1'b1;

    // RG6 from 0x0400
    run_cycles(3 * LINE + 137, 0);
    // Alpha: twelve-line row repeat, then the next row
    do_reset(4'b0000, 13'h0400);
    run_cycles(14 * LINE + 61, 0);
    // CG1: 16-dot byte period, three-line rows
    do_reset(4'b1000, 13'h0400);
    run_cycles(8 * LINE + 300, 0);
    // Address wrap past 0x1FFF
    do_reset(4'b1111, 13'h1FF0);
    run_cycles(3 * LINE + 20, 0);
    // RG6 -> CG1 switch at dot 100 of line 0
    do_reset(4'b1111, 13'h0400);
    sw_en = 1; sw_h = 100; sw_mode = 4'b1000;
    run_cycles(3 * LINE + 211, 0);
    // Randomized mode and base churn, two frames-starts
    do_reset(4'($urandom()), 13'($urandom()));
    run_cycles(10 * LINE + int'($urandom_range(1, 455)), 1);
    do_reset(4'($urandom()), 13'($urandom()));
    run_cycles(10 * LINE + int'($urandom_range(1, 455)), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
